psram_xfer_arb: RTL
===================

Name: psram_xfer_arb

Overview:
Arbitrates the single psram_core transfer port between two requesters: the APB configuration path (cfg, manual command/data transfers) and the AXI slave FSM (bus, memory transfers). It grants one request at a time with round-robin on ties. It drives the core's xfer_valid/xfer_rdwr/address/data and returns completion, read data and timeout status to the winner. It sits between the register/AXI front ends and psram_core, on the core clock.

Parameters:
ADDR_WIDTH, 32, transfer address width
DATA_WIDTH, 64, transfer data width
MASK_WIDTH, 8, byte write-mask width (DATA_WIDTH/8)
TMO_WIDTH, 16, timeout counter width; timeout after 2**TMO_WIDTH-1 cycles

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  arbiter enable; 0 blocks new grants
gap_i  in  8  idle cycles inserted between consecutive transfers
cfg_req_i  in  1  cfg request, level, held until cfg_done_o
cfg_rdwr_i  in  1  cfg direction, 1=read 0=write
cfg_addr_i  in  ADDR_WIDTH  cfg address
cfg_wdata_i  in  DATA_WIDTH  cfg write data
cfg_wmask_i  in  MASK_WIDTH  cfg byte mask
cfg_done_o  out  1  one-cycle completion pulse to cfg
bus_req_i, bus_rdwr_i, bus_addr_i, bus_wdata_i, bus_wmask_i  in  1/1/ADDR_WIDTH/DATA_WIDTH/MASK_WIDTH  same as cfg_* for bus
bus_done_o  out  1  one-cycle completion pulse to bus
rdata_o  out  DATA_WIDTH  read data, valid in the done cycle, held until next done
xfer_valid_o  out  1  transfer request to core
xfer_rdwr_o  out  1  latched direction
xfer_addr_o  out  ADDR_WIDTH  latched address
xfer_wdata_o  out  DATA_WIDTH  latched write data
xfer_wmask_o  out  MASK_WIDTH  latched mask
xfer_ready_i  in  1  core idle (1) / busy (0)
xfer_done_i  in  1  core completion pulse
xfer_rdata_i  in  DATA_WIDTH  core read data, valid with xfer_done_i
busy_o  out  1  state != IDLE
owner_o  out  1  current/last owner, 0=cfg 1=bus
tmo_o  out  1  sticky timeout flag
tmo_clr_i  in  1  clears tmo_o

Behaviour:
- Reset: state IDLE; every output 0, except owner_o=1 (last=bus, so cfg wins the first tie). Reset applies at the next edge from any state, and an in-flight transfer is abandoned without a done pulse.
- IDLE: a grant needs en_i=1 and xfer_ready_i=1. With a single requester, grant it. With both, grant the one that is not owner_o.
  - On grant: latch the winner's rdwr/addr/wdata/wmask into xfer_*_o, set owner_o, clear the timeout counter, go to ISSUE.
- ISSUE: xfer_valid_o=1. Stay until xfer_ready_i=0 (core accepted), then xfer_valid_o=0 and go to WAIT.
  - If xfer_done_i arrives while still in ISSUE, treat it as accept plus done in the same cycle and go straight to the DONE action.
- WAIT: on xfer_done_i, capture xfer_rdata_i into rdata_o (reads only; unchanged on writes), pulse the owner's done for 1 cycle (the cycle after xfer_done_i), then go to GAP.
- GAP: count gap_i cycles, then go to IDLE. gap_i=0 means IDLE the next cycle. gap_i is sampled on entry to GAP.
- Timeout: the counter runs in ISSUE and WAIT. When it saturates: set tmo_o, pulse the owner's done with rdata_o unchanged, drop xfer_valid_o, go to GAP.
  - tmo_clr_i clears tmo_o; if set and clear happen in the same cycle, set wins.
- Minimum grant-to-done latency: 3 cycles (grant → ISSUE, core accept, done-pulse cycle).
- Request withdrawn after grant: ignored; the transfer completes and done still pulses.
- Request inputs change after grant: ignored, because xfer_*_o are latched.
- en_i=0 mid-transfer: the current transfer completes normally; no further grants.
- The two done outputs are never high in the same cycle. At most one transfer is outstanding.

Test Plan:
- cfg only: cfg_req=1, rdwr=0, addr=0x40, wdata=0xA5, mask=0x01; core drops ready 1 cycle after valid, done 5 cycles later → xfer_addr_o=0x40, xfer_valid_o high exactly 1 cycle, cfg_done_o one pulse, bus_done_o stays 0.
- Tie round-robin: cfg and bus both request continuously, gap_i=0, 4 transfers → grant order cfg, bus, cfg, bus; owner_o toggles 0,1,0,1.
- Bus read: bus_rdwr=1, xfer_rdata_i=0x0123456789ABCDEF with done → rdata_o=0x0123456789ABCDEF in the bus_done_o cycle and held afterward; a following write leaves it unchanged.
- Gap: gap_i=3, back-to-back bus requests → exactly 3 idle cycles between the done pulse and the next xfer_valid_o rise; busy_o high throughout GAP.
- Timeout: TMO_WIDTH=4, core never returns done → after 15 cycles in ISSUE/WAIT, tmo_o=1 and the owner's done pulses; a tmo_clr_i pulse returns tmo_o to 0.
- Reset/enable: rst_i during WAIT → next cycle all outputs 0, owner_o=1, no done pulse. en_i=0 with pending requests → no xfer_valid_o.

Source files
------------

// File: rtl/psram_xfer_arb.sv
// Two-way arbiter in front of the psram_core transfer port: cfg (APB) and bus (AXI) requesters,
// round-robin on ties, with a per-transfer timeout and a programmable idle gap between transfers.
module psram_xfer_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MASK_WIDTH = 8,
  parameter int unsigned TMO_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [7:0]            gap_i,
  input  logic                  cfg_req_i,
  input  logic                  cfg_rdwr_i,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_wdata_i,
  input  logic [MASK_WIDTH-1:0] cfg_wmask_i,
  output logic                  cfg_done_o,
  input  logic                  bus_req_i,
  input  logic                  bus_rdwr_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  input  logic [MASK_WIDTH-1:0] bus_wmask_i,
  output logic                  bus_done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  xfer_valid_o,
  output logic                  xfer_rdwr_o,
  output logic [ADDR_WIDTH-1:0] xfer_addr_o,
  output logic [DATA_WIDTH-1:0] xfer_wdata_o,
  output logic [MASK_WIDTH-1:0] xfer_wmask_o,
  input  logic                  xfer_ready_i,
  input  logic                  xfer_done_i,
  input  logic [DATA_WIDTH-1:0] xfer_rdata_i,
  output logic                  busy_o,
  output logic                  owner_o,
  output logic                  tmo_o,
  input  logic                  tmo_clr_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rdwr_q, rdwr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cfg_done_q, cfg_done_d;
  logic                  bus_done_q, bus_done_d;
  logic                  tmo_q, tmo_d;
  logic [TMO_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;

  logic                  pick_bus;
  logic                  fin_ok;
  logic                  fin_tmo;
  logic [TMO_WIDTH-1:0]  tmo_inc;
  logic                  tmo_hit;

  // On a tie the requester that did not own the last transfer wins.
  assign pick_bus = bus_req_i & (~cfg_req_i | ~owner_q);
  assign tmo_inc  = tmo_cnt_q + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
  assign tmo_hit  = (tmo_inc == {TMO_WIDTH{1'b1}});

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rdwr_d     = rdwr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    cfg_done_d = 1'b0;
    bus_done_d = 1'b0;
    fin_ok     = 1'b0;
    fin_tmo    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i && xfer_ready_i && (cfg_req_i || bus_req_i)) begin
          owner_d   = pick_bus;
          rdwr_d    = pick_bus ? bus_rdwr_i  : cfg_rdwr_i;
          addr_d    = pick_bus ? bus_addr_i  : cfg_addr_i;
          wdata_d   = pick_bus ? bus_wdata_i : cfg_wdata_i;
          mask_d    = pick_bus ? bus_wmask_i : cfg_wmask_i;
          tmo_cnt_d = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // A done seen while still issuing counts as accept and completion together.
        if (xfer_done_i) begin
          fin_ok = 1'b1;
        end else if (tmo_hit) begin
          fin_tmo = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (state_q == ST_ISSUE && !xfer_ready_i) begin
            state_d = ST_WAIT;
          end
        end
      end
      default: begin
        // The done-pulse cycle is the first gap cycle, so gap_i idle cycles precede the next issue.
        if (gap_cnt_q <= 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
    endcase

    if (fin_ok || fin_tmo) begin
      cfg_done_d = ~owner_q;
      bus_done_d = owner_q;
      gap_cnt_d  = gap_i;
      state_d    = ST_GAP;
      if (fin_ok && rdwr_q) begin
        rdata_d = xfer_rdata_i;
      end
    end

    tmo_d = fin_tmo ? 1'b1 : (tmo_clr_i ? 1'b0 : tmo_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b1;
      rdwr_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      cfg_done_q <= 1'b0;
      bus_done_q <= 1'b0;
      tmo_q      <= 1'b0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rdwr_q     <= rdwr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      cfg_done_q <= cfg_done_d;
      bus_done_q <= bus_done_d;
      tmo_q      <= tmo_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign xfer_valid_o = (state_q == ST_ISSUE);
  assign busy_o       = (state_q != ST_IDLE);
  assign xfer_rdwr_o  = rdwr_q;
  assign xfer_addr_o  = addr_q;
  assign xfer_wdata_o = wdata_q;
  assign xfer_wmask_o = mask_q;
  assign rdata_o      = rdata_q;
  assign cfg_done_o   = cfg_done_q;
  assign bus_done_o   = bus_done_q;
  assign owner_o      = owner_q;
  assign tmo_o        = tmo_q;

endmodule
